// File: rtl/pre_if_stage_pkg.sv
// Shared types and constants for the pre-IF stage: bus width, reset PC, state encodings.
// PREIF_ADEF_CHECK_EN adds the ADEF_HOLD state for misaligned-fetch tokens.
package pre_if_stage_pkg;

    localparam int          WIDTH_PFS_TO_FS_BUS = 34;
    localparam logic [31:0] RESET_PC            = 32'h1C000000;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1
`ifdef PREIF_ADEF_CHECK_EN
        ,
        S_ADEF_HOLD = 2'd2
`endif
    } pfs_state_e;

    // adef sits in the MSB, then discard, then the 32-bit PC.
    typedef struct packed {
        logic        adef;
        logic        discard;
        logic [31:0] pc;
    } pfs_to_fs_t;

    // Sequential fetch advance; wraps modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pre_if_stage_redirect_sel.sv
// redirect_sel: priority mux of the three redirect sources.
// Ports: wb_ex/ex_entry, ertn_flush/ertn_pc, br_taken/br_target in; redirect, target out.
module redirect_sel (
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        redirect,
    output logic [31:0] target
);

    always_comb begin
        redirect = wb_ex | ertn_flush | br_taken;
        // Exception beats ertn beats branch.
        if (wb_ex) begin
            target = ex_entry;
        end else if (ertn_flush) begin
            target = ertn_pc;
        end else begin
            target = br_target;
        end
    end

endmodule

// File: rtl/pre_if_stage.sv
// pre_if_stage: holds the next fetch PC, drives the inst SRAM request phase and hands IF
// {adef, discard, pc} per accepted request. Ports: clk/reset, IF slot and redirect inputs,
// inst_sram_* request bus, pfs_to_fs_valid/bus. Optional macro: PREIF_ADEF_CHECK_EN.
module pre_if_stage
    import pre_if_stage_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           fs_allow_in,
    input  logic                           br_stall,
    input  logic                           br_taken,
    input  logic [31:0]                    br_target,
    input  logic                           ertn_flush,
    input  logic [31:0]                    ertn_pc,
    input  logic                           wb_ex,
    input  logic [31:0]                    ex_entry,
    output logic                           inst_sram_req,
    output logic                           inst_sram_wr,
    output logic [1:0]                     inst_sram_size,
    output logic [3:0]                     inst_sram_wstrb,
    output logic [31:0]                    inst_sram_addr,
    output logic [31:0]                    inst_sram_wdata,
    input  logic                           inst_sram_addr_ok,
    output logic                           pfs_to_fs_valid,
    output logic [WIDTH_PFS_TO_FS_BUS-1:0] pfs_to_fs_bus
);

    logic        redirect;
    logic [31:0] target;

    pfs_state_e  state;
    logic [31:0] pfs_pc;
    logic [31:0] req_addr;
    logic        redir_seen;

    logic        hs;
    logic        start_ok;
    logic        start;
    logic        token;
    pfs_to_fs_t  bus;

`ifdef PREIF_ADEF_CHECK_EN
    logic        adef_pend;
    logic        misaligned;
`endif

    redirect_sel u_redirect_sel (
        .wb_ex      (wb_ex),
        .ex_entry   (ex_entry),
        .ertn_flush (ertn_flush),
        .ertn_pc    (ertn_pc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .redirect   (redirect),
        .target     (target)
    );

    // Write-side bus fields are fixed: this port only reads words.
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_wdata = 32'd0;

    // Gated by reset so a reset mid-request drops req in the same cycle.
    assign inst_sram_req  = (state == S_REQ) & ~reset;
    assign inst_sram_addr = req_addr;

    assign hs       = inst_sram_req & inst_sram_addr_ok;
    assign start_ok = fs_allow_in & ~br_stall & ~redirect;
    assign start    = start_ok & ((state == S_IDLE) | hs);

`ifdef PREIF_ADEF_CHECK_EN
    assign misaligned = pfs_pc[1:0] != 2'b00;
    assign token      = (state == S_ADEF_HOLD) & adef_pend & ~reset;
`else
    assign token      = 1'b0;
`endif

    assign pfs_to_fs_valid = hs | token;

    always_comb begin
        bus = '0;
        if (hs) begin
            bus.adef    = 1'b0;
            bus.discard = redir_seen | redirect;
            bus.pc      = req_addr;
        end else if (token) begin
            // The faulting PC was parked in req_addr when the token was raised.
            bus.adef    = 1'b1;
            bus.discard = 1'b0;
            bus.pc      = req_addr;
        end
    end

    assign pfs_to_fs_bus = bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pfs_pc     <= RESET_PC;
            req_addr   <= 32'd0;
            redir_seen <= 1'b0;
`ifdef PREIF_ADEF_CHECK_EN
            adef_pend  <= 1'b0;
`endif
        end else begin
            // A redirect while stalled marks the pending request as wrong-path.
            if (hs) begin
                redir_seen <= 1'b0;
            end else if ((state == S_REQ) && redirect) begin
                redir_seen <= 1'b1;
            end

            if (start) begin
`ifdef PREIF_ADEF_CHECK_EN
                if (misaligned) begin
                    state     <= S_ADEF_HOLD;
                    req_addr  <= pfs_pc;
                    adef_pend <= 1'b1;
                end else begin
                    state     <= S_REQ;
                    req_addr  <= pfs_pc;
                    pfs_pc    <= next_seq_pc(pfs_pc);
                end
`else
                state    <= S_REQ;
                req_addr <= pfs_pc;
                pfs_pc   <= next_seq_pc(pfs_pc);
`endif
            end else if (hs) begin
                state <= S_IDLE;
            end
`ifdef PREIF_ADEF_CHECK_EN
            else if (state == S_ADEF_HOLD) begin
                adef_pend <= 1'b0;
                if (redirect) begin
                    state <= S_IDLE;
                end
            end
`endif

            // Redirect target overrides the sequential advance.
            if (redirect) begin
                pfs_pc <= target;
            end
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// tb_pre_if_stage: directed bench for pre_if_stage with a scoreboard of expected
// IF tokens. The ADEF section runs only when PREIF_ADEF_CHECK_EN is defined.
module tb_pre_if_stage;

    logic        clk;
    logic        reset;
    logic        fs_allow_in;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ertn_flush;
    logic [31:0] ertn_pc;
    logic        wb_ex;
    logic [31:0] ex_entry;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        pfs_to_fs_valid;
    logic [33:0] pfs_to_fs_bus;

    int n_checks = 0;
    int n_errors = 0;
    logic [33:0] sb[$];

    pre_if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allow_in       (fs_allow_in),
        .br_stall          (br_stall),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .ertn_flush        (ertn_flush),
        .ertn_pc           (ertn_pc),
        .wb_ex             (wb_ex),
        .ex_entry          (ex_entry),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .pfs_to_fs_valid   (pfs_to_fs_valid),
        .pfs_to_fs_bus     (pfs_to_fs_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] tok(input logic adef, input logic disc, input logic [31:0] pc);
        return {adef, disc, pc};
    endfunction

    // Sample at the falling edge; pop one expectation per valid pulse.
    task automatic sample();
        @(negedge clk);
        if (pfs_to_fs_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 34'(pfs_to_fs_valid), 34'd0);
            end else begin
                chk("fs_token", pfs_to_fs_bus, sb.pop_front());
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic req_is(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, 34'(inst_sram_req), 34'(r));
        if (r) chk({tag, "_addr"}, 34'(inst_sram_addr), 34'(a));
    endtask

    task automatic vld_is(input string tag, input logic v);
        chk({tag, "_valid"}, 34'(pfs_to_fs_valid), 34'(v));
    endtask

    initial begin
        reset = 1'b1;
        fs_allow_in = 1'b0;
        br_stall = 1'b0;
        br_taken = 1'b0;
        br_target = 32'd0;
        ertn_flush = 1'b0;
        ertn_pc = 32'd0;
        wb_ex = 1'b0;
        ex_entry = 32'd0;
        inst_sram_addr_ok = 1'b0;

        adv(); adv(); adv();
        sample();
        chk("rst_req", 34'(inst_sram_req), 34'd0);
        chk("rst_valid", 34'(pfs_to_fs_valid), 34'd0);
        chk("rst_bus", pfs_to_fs_bus, 34'd0);
        chk("rst_addr", 34'(inst_sram_addr), 34'd0);
        chk("const_wr", 34'(inst_sram_wr), 34'd0);
        chk("const_size", 34'(inst_sram_size), 34'd2);
        chk("const_wstrb", 34'(inst_sram_wstrb), 34'd0);
        chk("const_wdata", 34'(inst_sram_wdata), 34'd0);

        // Reset release, back-to-back fetch.
        adv();
        reset = 1'b0; fs_allow_in = 1'b1; inst_sram_addr_ok = 1'b1;
        sample();
        req_is("post_rst", 1'b0, 32'd0);
        vld_is("post_rst", 1'b0);
        for (int i = 0; i < 3; i++) begin
            adv();
            sb.push_back(tok(1'b0, 1'b0, 32'h1C000000 + 32'(4 * i)));
            sample();
            req_is("seq", 1'b1, 32'h1C000000 + 32'(4 * i));
            vld_is("seq", 1'b1);
        end

        // Stall on addr_ok with a branch in the middle of the stall.
        adv();
        inst_sram_addr_ok = 1'b0;
        sample();
        req_is("stall1", 1'b1, 32'h1C00000C);
        vld_is("stall1", 1'b0);
        adv();
        br_taken = 1'b1; br_target = 32'h1C000100;
        sample();
        req_is("stall2", 1'b1, 32'h1C00000C);
        vld_is("stall2", 1'b0);
        adv();
        br_taken = 1'b0;
        sample();
        req_is("stall3", 1'b1, 32'h1C00000C);
        vld_is("stall3", 1'b0);
        adv();
        inst_sram_addr_ok = 1'b1;
        sb.push_back(tok(1'b0, 1'b1, 32'h1C00000C));
        sample();
        vld_is("stall_hs", 1'b1);
        adv();
        sb.push_back(tok(1'b0, 1'b0, 32'h1C000100));
        sample();
        req_is("br_tgt", 1'b1, 32'h1C000100);

        // Branch and exception together: exception entry wins.
        adv();
        br_taken = 1'b1; br_target = 32'h1C000200;
        wb_ex = 1'b1; ex_entry = 32'h1C008000;
        sb.push_back(tok(1'b0, 1'b1, 32'h1C000104));
        sample();
        vld_is("ex_hs", 1'b1);
        adv();
        br_taken = 1'b0; wb_ex = 1'b0;
        sample();
        req_is("ex_gap", 1'b0, 32'd0);
        vld_is("ex_gap", 1'b0);
        adv();
        sb.push_back(tok(1'b0, 1'b0, 32'h1C008000));
        sample();
        req_is("ex_tgt", 1'b1, 32'h1C008000);

        // br_stall for 4 cycles; in-flight request still completes.
        adv();
        br_stall = 1'b1;
        sb.push_back(tok(1'b0, 1'b0, 32'h1C008004));
        sample();
        vld_is("bs_hs", 1'b1);
        for (int i = 0; i < 3; i++) begin
            adv();
            sample();
            req_is("bs_hold", 1'b0, 32'd0);
            vld_is("bs_hold", 1'b0);
        end
        adv();
        br_stall = 1'b0;
        sample();
        req_is("bs_fall", 1'b0, 32'd0);
        adv();
        sb.push_back(tok(1'b0, 1'b0, 32'h1C008008));
        sample();
        req_is("bs_resume", 1'b1, 32'h1C008008);

        // ertn coincident with a handshake.
        adv();
        ertn_flush = 1'b1; ertn_pc = 32'h1C000400;
        sb.push_back(tok(1'b0, 1'b1, 32'h1C00800C));
        sample();
        vld_is("ertn_hs", 1'b1);
        adv();
        ertn_flush = 1'b0;
        sample();
        req_is("ertn_gap", 1'b0, 32'd0);
        adv();
        sb.push_back(tok(1'b0, 1'b0, 32'h1C000400));
        sample();
        req_is("ertn_tgt", 1'b1, 32'h1C000400);

        // Slot was reserved at start: handshake still taken with fs_allow_in low.
        adv();
        fs_allow_in = 1'b0;
        sb.push_back(tok(1'b0, 1'b0, 32'h1C000404));
        sample();
        vld_is("no_slot_hs", 1'b1);
        adv();
        sample();
        req_is("no_slot_idle", 1'b0, 32'd0);
        vld_is("no_slot_idle", 1'b0);

`ifdef PREIF_ADEF_CHECK_EN
        adv();
        fs_allow_in = 1'b1; br_taken = 1'b1; br_target = 32'h1C000102;
        sample();
        req_is("adef_redir", 1'b0, 32'd0);
        adv();
        br_taken = 1'b0;
        sample();
        req_is("adef_start", 1'b0, 32'd0);
        vld_is("adef_start", 1'b0);
        adv();
        sb.push_back(tok(1'b1, 1'b0, 32'h1C000102));
        sample();
        req_is("adef_tok", 1'b0, 32'd0);
        vld_is("adef_tok", 1'b1);
        for (int i = 0; i < 2; i++) begin
            adv();
            sample();
            req_is("adef_hold", 1'b0, 32'd0);
            vld_is("adef_hold", 1'b0);
        end
        adv();
        wb_ex = 1'b1; ex_entry = 32'h1C008000;
        sample();
        req_is("adef_ex", 1'b0, 32'd0);
        vld_is("adef_ex", 1'b0);
        adv();
        wb_ex = 1'b0;
        sample();
        req_is("adef_idle", 1'b0, 32'd0);
        adv();
        fs_allow_in = 1'b0;
        sb.push_back(tok(1'b0, 1'b0, 32'h1C008000));
        sample();
        req_is("adef_resume", 1'b1, 32'h1C008000);
        adv();
        sample();
        req_is("adef_done", 1'b0, 32'd0);
`endif

        chk("sb_empty", 34'(sb.size()), 34'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pre_if_stage.md
# pre_if_stage

Pre-IF stage of the five-stage pipeline, directly upstream of the IF stage. It holds the next fetch PC, drives the instruction-side SRAM-like bus request phase (req/addr_ok), and buffers redirects (exception, ertn, branch) that arrive while a request is stalled on the bus. For every accepted request it hands IF the PC plus a discard flag. IF then drops the matching data_ok response when the request was issued on a wrong path.

## Interface
- `RESET_PC`, 32'h1C000000, first PC fetched after reset
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `fs_allow_in`  in  1  IF can reserve a slot for one more accepted request
- `br_stall`  in  1  ID holds an unresolved branch; no new request may start
- `br_taken`  in  1  branch redirect
- `br_target`  in  32  branch target
- `ertn_flush`  in  1  ertn redirect
- `ertn_pc`  in  32  ERA value
- `wb_ex`  in  1  exception/interrupt redirect from WB
- `ex_entry`  in  32  exception entry
- `inst_sram_req`  out  1  bus request
- `inst_sram_wr`  out  1  constant 0
- `inst_sram_size`  out  2  constant 2'd2
- `inst_sram_wstrb`  out  4  constant 0
- `inst_sram_addr`  out  32  request address
- `inst_sram_wdata`  out  32  constant 0
- `inst_sram_addr_ok`  in  1  address accepted
- `pfs_to_fs_valid`  out  1  one-cycle pulse per accepted request, or per ADEF token
- `pfs_to_fs_bus`  out  34  {adef, discard, pc[31:0]}

## Operation
- Redirect is `wb_ex | ertn_flush | br_taken`. Target priority: `ex_entry` > `ertn_pc` > `br_target`.
- Registers:
  - `pfs_pc`: next PC to issue.
  - `req_addr`: address of the request in flight.
  - `redir_seen`.
  - `state`: IDLE, REQ, or ADEF_HOLD. ADEF_HOLD exists only with the macro.
- Start condition: `fs_allow_in & ~br_stall & ~redirect`, evaluated in IDLE or in a REQ handshake cycle.
- On start: `req_addr <= pfs_pc`, `pfs_pc <= pfs_pc + 4`, `state <= REQ`.
- Bus outputs: `inst_sram_req = (state == REQ)`; `inst_sram_addr = req_addr`. Both stay stable until `addr_ok`.
- Handshake is `req & addr_ok`. In that cycle:
  - `pfs_to_fs_valid = 1`.
  - Bus carries `pc = req_addr` and `discard = redir_seen | redirect`.
  - `redir_seen` clears.
  - Next state is REQ if the start condition holds, else IDLE.
- A redirect in any state loads `pfs_pc <= target` (overrides +4).
- A redirect in REQ without `addr_ok` sets `redir_seen`.
- 32-bit PC arithmetic wraps modulo 2^32 with no special handling.
- IF contract: once a request starts, IF accepts its handshake even if `fs_allow_in` has since dropped, because the slot was reserved at start.

## Timing
- During reset and the cycle after: `state = IDLE`, `pfs_pc = RESET_PC`, all outputs 0.
- The first `req` is asserted in the second cycle after reset deasserts.
- Redirect to request latency is 1 cycle. The redirect cycle never starts a request; the next cycle starts `req` at the target.
- Throughput is one request per cycle when `addr_ok` is held high.
- Simultaneous redirect and handshake: the handshaken request gets `discard = 1`, and `pfs_pc` takes the target.
- Multiple redirects while stalled: the last (highest-priority) target wins, and `redir_seen` stays set.
- Reset mid-request drops `req` immediately. The bus is reset together with this stage.

## Configuration
- `PREIF_ADEF_CHECK_EN` defined:
  - At start, if `pfs_pc[1:0] != 0`, no bus request is issued.
  - Instead, `pfs_to_fs_valid` pulses with `adef = 1`, `discard = 0`, `pc = pfs_pc`, and the stage enters ADEF_HOLD.
  - ADEF_HOLD issues nothing until a redirect, then returns to IDLE with the new `pfs_pc`.
- Undefined: `adef` is tied to 0, there is no ADEF_HOLD, and a misaligned PC is issued to the bus unchanged.

## Structure
- Shared package/header `mycpu_head.vh` gains `WIDTH_PFS_TO_FS_BUS` (34), `RESET_PC`, and state encodings.
- One natural sub-module: `redirect_sel`, the combinational priority mux producing `redirect` and `target`.

## Test plan
- Reset release with `addr_ok = 1`, `fs_allow_in = 1`: requests at 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles, all with `discard = 0`.
- `addr_ok = 0` for 3 cycles with `br_taken` (target 0x1C000100) in cycle 2: `addr` stays at the old PC, the handshake carries `discard = 1`, and the next request is 0x1C000100.
- `br_taken` and `wb_ex` in the same cycle (`ex_entry` 0x1C008000): the next request is at 0x1C008000.
- `br_stall = 1` for 4 cycles: no `req`; the request resumes the cycle after `br_stall` falls.
- `ertn_flush` coincident with a handshake: that handshake has `discard = 1`; the next request is at `ertn_pc`.
- With macro, `br_target` 0x1C000102: no `req`, one token with `adef = 1` and `pc = 0x1C000102`, then silence until `wb_ex`, then a request at `ex_entry`.
